// File: rtl/mem_stage_sram_pkg.sv
// MEM stage SRAM port: shared widths and FSM state encoding.
// Imported by the top and the wait counter.
package mem_stage_sram_pkg;

    localparam int WORD_LEN      = 32;
    localparam int SRAM_ADDR_LEN = 18;
    localparam int SRAM_DATA_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_stage_sram_wait_counter.sv
// Per-phase wait counter for the SRAM port.
// Counts 0..WAIT_CYCLES-1 while enabled, flags the last two counts.
module mem_stage_sram_wait_counter
    import mem_stage_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_last,
    output logic o_pre_last
);

    localparam int CW = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] PRE  = CW'(WAIT_CYCLES - 2);

    logic [CW-1:0] r_cnt;

    // Count within a phase, wrapping at the last cycle for the next phase.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_last     = (r_cnt == LAST);
    assign o_pre_last = (r_cnt == PRE);

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage memory port: one 32-bit load/store as two 16-bit SRAM accesses.
// freeze stalls the pipeline until the access reaches DONE.
module mem_stage_sram
    import mem_stage_sram_pkg::*;
#(
    parameter int WORD_LEN    = mem_stage_sram_pkg::WORD_LEN,
    parameter int SRAM_ADDR_W = SRAM_ADDR_LEN,
    parameter int SRAM_DATA_W = SRAM_DATA_LEN,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BASE   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [WORD_LEN-1:0]    aluRes,
    input  logic [WORD_LEN-1:0]    storeData,
    output logic [WORD_LEN-1:0]    readData,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);

    state_t r_state;
    state_t w_next;

    logic                   r_wr;
    logic                   r_dq_oe;
    logic [SRAM_DATA_W-1:0] r_dq_out;
    logic [SRAM_DATA_W-1:0] r_wdata_hi;
    logic [SRAM_DATA_W-1:0] r_rd_lo;

    logic                   w_req;
    logic                   w_wr;
    logic                   w_busy;
    logic                   w_last;
    logic                   w_pre_last;
    logic [WORD_LEN-1:0]    w_off;
    logic [SRAM_ADDR_W-1:0] w_lo_addr;

    // A read wins when both enables are set.
    assign w_req     = MEM_R_EN | MEM_W_EN;
    assign w_wr      = MEM_W_EN & ~MEM_R_EN;
    assign w_off     = aluRes - WORD_LEN'(ADDR_BASE);
    assign w_lo_addr = SRAM_ADDR_W'({w_off >> 2, 1'b0});

    assign SRAM_DQ = r_dq_oe ? r_dq_out : {SRAM_DATA_W{1'bz}};

    mem_stage_sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (~w_busy),
        .i_en      (w_busy),
        .o_last    (w_last),
        .o_pre_last(w_pre_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: IDLE -> LO -> HI -> DONE -> IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_req)  w_next = ST_LO;
            ST_LO:   if (w_last) w_next = ST_HI;
            ST_HI:   if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Stall while a request is pending or a phase is running.
    always_comb begin
        w_busy = (r_state == ST_LO) || (r_state == ST_HI);
        freeze = ~rst & (((r_state == ST_IDLE) & w_req) | w_busy);
    end

    // SRAM bus registers and load capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            readData   <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WE_N  <= 1'b1;
            r_dq_oe    <= 1'b0;
            r_dq_out   <= '0;
            r_wr       <= 1'b0;
            r_wdata_hi <= '0;
            r_rd_lo    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_wr       <= w_wr;
                        r_wdata_hi <= storeData[WORD_LEN-1:SRAM_DATA_W];
                        r_dq_out   <= storeData[SRAM_DATA_W-1:0];
                        r_dq_oe    <= w_wr;
                        SRAM_WE_N  <= ~w_wr;
                        SRAM_ADDR  <= w_lo_addr;
                    end
                end
                ST_LO: begin
                    if (w_last) begin
                        SRAM_ADDR <= {SRAM_ADDR[SRAM_ADDR_W-1:1], 1'b1};
                        r_dq_out  <= r_wdata_hi;
                        SRAM_WE_N <= ~r_wr;
                        if (!r_wr) r_rd_lo <= SRAM_DQ;
                    end else begin
                        SRAM_WE_N <= ~(r_wr & ~w_pre_last);
                    end
                end
                ST_HI: begin
                    if (w_last) begin
                        SRAM_WE_N <= 1'b1;
                        r_dq_oe   <= 1'b0;
                        if (!r_wr) readData <= {SRAM_DQ, r_rd_lo};
                    end else begin
                        SRAM_WE_N <= ~(r_wr & ~w_pre_last);
                    end
                end
                ST_DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Randomized bench for mem_stage_sram with a half-word SRAM model
// and a word-level reference memory.
module tb_mem_stage_sram;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] aluRes = '0;
    logic [31:0] storeData = '0;
    wire  [31:0] readData;
    wire         freeze;
    wire  [17:0] SRAM_ADDR;
    wire         SRAM_WE_N;
    wire  [15:0] SRAM_DQ;

    logic [15:0] m_mem [256];
    logic        m_init = 1'b0;
    logic        m_prev_we = 1'b1;
    logic        mon_off = 1'b0;
    logic        tb_rd = 1'b0;
    logic [31:0] ref_word [128];
    logic [31:0] last_rd;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_stage_sram #(
        .WAIT_CYCLES(W),
        .ADDR_BASE  (1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MEM_R_EN (MEM_R_EN),
        .MEM_W_EN (MEM_W_EN),
        .aluRes   (aluRes),
        .storeData(storeData),
        .readData (readData),
        .freeze   (freeze),
        .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N),
        .SRAM_DQ  (SRAM_DQ)
    );

    // SRAM drives the bus on reads while the write strobe is high.
    assign SRAM_DQ = (tb_rd && SRAM_WE_N) ? m_mem[SRAM_ADDR[7:0]] : 16'bz;

    function automatic logic [15:0] seed(int a);
        return 16'(a * 40503 + 12345);
    endfunction

    // SRAM model: commit on the rising edge of the write strobe.
    always @(negedge clk) begin
        if (!m_init) begin
            for (int i = 0; i < 256; i++) m_mem[i] <= seed(i);
            m_init <= 1'b1;
        end else if (!mon_off && !m_prev_we && SRAM_WE_N) begin
            m_mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
        end
        m_prev_we <= SRAM_WE_N;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MEM_R_EN = 1'b0;
            MEM_W_EN = 1'b0;
            aluRes = $urandom;
            @(negedge clk);
            chk("idle_freeze", 32'(freeze), 32'd0);
            chk("idle_we_n", 32'(SRAM_WE_N), 32'd1);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input int w,
                          input logic [31:0] data);
        bit          do_wr;
        bit          done;
        int          nf;
        int          nwe;
        logic [17:0] a_lo;
        logic [17:0] a_hi;
        logic [15:0] dq_lo;
        logic [15:0] dq_hi;
        logic [31:0] rdv;
        do_wr = wr && !rd;
        done = 1'b0;
        nwe = 0;
        a_lo = '0;
        a_hi = '0;
        dq_lo = '0;
        dq_hi = '0;
        rdv = '0;
        @(posedge clk); #1;
        MEM_R_EN = rd;
        MEM_W_EN = wr;
        aluRes = 32'(1024 + w * 4 + int'($urandom_range(0, 3)));
        storeData = data;
        tb_rd = rd;
        @(negedge clk);
        nf = freeze ? 1 : 0;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(posedge clk); #1;
            MEM_R_EN = 1'($urandom);
            MEM_W_EN = 1'($urandom);
            aluRes = $urandom;
            storeData = $urandom;
            @(negedge clk);
            if (!SRAM_WE_N) nwe++;
            if (c == 1) begin
                a_lo = SRAM_ADDR;
                dq_lo = SRAM_DQ;
            end
            if (c == W + 1) begin
                a_hi = SRAM_ADDR;
                dq_hi = SRAM_DQ;
            end
            if (freeze) nf++;
            else begin
                done = 1'b1;
                rdv = readData;
            end
        end
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        tb_rd = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("freeze_len", 32'(nf), 32'(2 * W + 1));
        chk("addr_lo", 32'(a_lo), 32'(2 * w));
        chk("addr_hi", 32'(a_hi), 32'(2 * w + 1));
        chk("we_low_cycles", 32'(nwe), do_wr ? 32'(2 * (W - 1)) : 32'd0);
        if (do_wr) begin
            chk("dq_lo", 32'(dq_lo), 32'(data[15:0]));
            chk("dq_hi", 32'(dq_hi), 32'(data[31:16]));
            chk("mem_lo", 32'(m_mem[2 * w]), 32'(data[15:0]));
            chk("mem_hi", 32'(m_mem[2 * w + 1]), 32'(data[31:16]));
            chk("wr_keeps_rd", rdv, last_rd);
            ref_word[w] = data;
        end else begin
            chk("load_data", rdv, ref_word[w]);
            last_rd = ref_word[w];
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++)
            ref_word[i] = {seed(2 * i + 1), seed(2 * i)};
        last_rd = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readdata", readData, 32'd0);
        chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_freeze", 32'(freeze), 32'd0);

        access(1'b0, 1'b1, 1, 32'hDEADBEEF);
        access(1'b1, 1'b0, 1, 32'h0);
        access(1'b1, 1'b0, 1, 32'h0);
        access(1'b1, 1'b0, 2, 32'h0);

        @(posedge clk); #1;
        MEM_W_EN = 1'b1;
        aluRes = 32'd1060;
        storeData = 32'h12345678;
        @(posedge clk); #1;
        MEM_W_EN = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_hi_we_n", 32'(SRAM_WE_N), 32'd0);
        mon_off = 1'b1;
        rst = 1'b1;
        #1;
        chk("abort_rst_freeze", 32'(freeze), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("abort_freeze", 32'(freeze), 32'd0);
        chk("abort_lo_commit", 32'(m_mem[18]), 32'h5678);
        @(posedge clk); #1;
        mon_off = 1'b0;
        ref_word[9][15:0] = 16'h5678;
        access(1'b1, 1'b0, 9, 32'h0);

        access(1'b1, 1'b1, 1, 32'hCAFEF00D);
        idle(10);

        for (int t = 0; t < 40; t++) begin
            int op;
            idle(int'($urandom_range(0, 2)));
            op = int'($urandom_range(0, 2));
            access(op != 1, op != 0, int'($urandom_range(0, 127)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
